// File: rtl/board_stream_pkg.sv
// Shared constants for the Game-of-Life terminal stream: protocol bytes,
// default board geometry and the receive-side decoder states.
package board_stream_pkg;

  localparam int unsigned DEF_LOG_WIDTH  = 4;
  localparam int unsigned DEF_LOG_HEIGHT = 4;

  localparam logic [7:0] ESC          = 8'h1B;
  localparam logic [7:0] CSI_LBRACKET = 8'h5B;
  localparam logic [7:0] SEMI         = 8'h3B;
  localparam logic [7:0] HOME_H       = 8'h48;
  localparam logic [7:0] CELL_LIVE    = 8'h4F;
  localparam logic [7:0] CELL_DEAD    = 8'h20;
  localparam logic [7:0] CR           = 8'h0D;
  localparam logic [7:0] LF           = 8'h0A;

  typedef enum logic [2:0] {
    ST_HUNT = 3'd0,
    ST_CSI  = 3'd1,
    ST_SEMI = 3'd2,
    ST_HOME = 3'd3,
    ST_CELL = 3'd4,
    ST_CR   = 3'd5,
    ST_LF   = 3'd6
  } dec_state_e;

endpackage

// File: rtl/board_stream_decoder.sv
// Rebuilds a WIDTH x HEIGHT Game-of-Life board from the terminal byte stream
// and publishes each complete frame through a valid/ack handshake.
module board_stream_decoder
  import board_stream_pkg::*;
#(
  parameter int unsigned logWIDTH  = DEF_LOG_WIDTH,
  parameter int unsigned logHEIGHT = DEF_LOG_HEIGHT,
  localparam int unsigned WIDTH  = 2 ** logWIDTH,
  localparam int unsigned HEIGHT = 2 ** logHEIGHT,
  localparam int unsigned AW     = logWIDTH + logHEIGHT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_data,
  output logic          frame_valid,
  input  logic          frame_ack,
  output logic [AW:0]   frame_live,
  output logic [15:0]   frame_count,
  output logic          err_pulse,
  output logic [7:0]    err_count
);

  localparam int unsigned CELLS = WIDTH * HEIGHT;

  dec_state_e            state_q, state_d;
  logic [logHEIGHT-1:0]  row_q, row_d;
  logic [logWIDTH-1:0]   col_q, col_d;
  logic [AW:0]           live_q, live_d;
  logic                  frame_valid_d;

  logic                  accept_c;
  logic                  cell_we_c;
  logic                  cell_bit_c;
  logic                  err_c;
  logic                  done_c;

  logic [CELLS-1:0]      cells_q;

  assign accept_c = in_valid && in_ready;

  // Byte parser: next state, cursor, live accumulator and frame events
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    live_d        = live_q;
    cell_we_c     = 1'b0;
    cell_bit_c    = 1'b0;
    err_c         = 1'b0;
    done_c        = 1'b0;
    frame_valid_d = frame_valid;

    if (accept_c) begin
      case (state_q)
        ST_HUNT: begin
          if (in_data == ESC) state_d = ST_CSI;
        end
        ST_CSI: begin
          if (in_data == CSI_LBRACKET) state_d = ST_SEMI;
          else                         err_c   = 1'b1;
        end
        ST_SEMI: begin
          if (in_data == SEMI) state_d = ST_HOME;
          else                 err_c   = 1'b1;
        end
        ST_HOME: begin
          if (in_data == HOME_H) begin
            state_d = ST_CELL;
            row_d   = '0;
            col_d   = '0;
            live_d  = '0;
          end else begin
            err_c = 1'b1;
          end
        end
        ST_CELL: begin
          if ((in_data == CELL_LIVE) || (in_data == CELL_DEAD)) begin
            cell_we_c  = 1'b1;
            cell_bit_c = (in_data == CELL_LIVE);
            if (cell_bit_c) live_d = live_q + (AW + 1)'(1);
            if (&col_q) begin
              if (&row_q) begin
                done_c  = 1'b1;
                state_d = ST_HUNT;
              end else begin
                col_d   = '0;
                state_d = ST_CR;
              end
            end else begin
              col_d = col_q + logWIDTH'(1);
            end
          end else begin
            err_c = 1'b1;
          end
        end
        ST_CR: begin
          if (in_data == CR) state_d = ST_LF;
          else               err_c   = 1'b1;
        end
        ST_LF: begin
          if (in_data == LF) begin
            row_d   = row_q + logHEIGHT'(1);
            state_d = ST_CELL;
          end else begin
            err_c = 1'b1;
          end
        end
        default: state_d = ST_HUNT;
      endcase

      // An ESC in the wrong place is still an error, but it starts a new header
      if (err_c) state_d = (in_data == ESC) ? ST_CSI : ST_HUNT;
    end

    if (done_c)                        frame_valid_d = 1'b1;
    else if (frame_valid && frame_ack) frame_valid_d = 1'b0;
  end

  // Parser state, handshake and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HUNT;
      row_q       <= '0;
      col_q       <= '0;
      live_q      <= '0;
      in_ready    <= 1'b0;
      frame_valid <= 1'b0;
      frame_live  <= '0;
      frame_count <= '0;
      err_pulse   <= 1'b0;
      err_count   <= '0;
      rd_data     <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      live_q      <= live_d;
      frame_valid <= frame_valid_d;
      in_ready    <= !frame_valid_d;
      err_pulse   <= err_c;
      if (err_c && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      if (done_c) begin
        frame_live  <= live_d;
        frame_count <= frame_count + 16'd1;
      end
      rd_data <= cells_q[rd_addr];
    end
  end

  // Frame buffer; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (cell_we_c) cells_q[{row_q, col_q}] <= cell_bit_c;
  end

endmodule

// File: tb/tb_board_stream_decoder.sv
// Directed-sequence bench for board_stream_decoder with random boards checked
// against a stream-position model of the frame buffer and counters.
module tb_board_stream_decoder;
  import board_stream_pkg::*;

  localparam int unsigned W           = 16;
  localparam int unsigned H           = 16;
  localparam int unsigned CELLS       = W * H;
  localparam int unsigned FRAME_BYTES = 4 + CELLS + 2 * (H - 1);
  localparam int unsigned ROW_STRIDE  = W + 2;
  localparam int          BOUND       = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] rd_addr = 8'h00;
  logic       rd_data;
  logic       frame_valid;
  logic       frame_ack = 1'b0;
  logic [8:0] frame_live;
  logic [15:0] frame_count;
  logic       err_pulse;
  logic [7:0] err_count;

  board_stream_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .frame_live  (frame_live),
    .frame_count (frame_count),
    .err_pulse   (err_pulse),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int err_seen = 0;
  int exp_err = 0;
  int exp_pulses = 0;
  int exp_frames = 0;

  bit cells[CELLS];
  bit exp_mem[CELLS];
  byte unsigned stream[$];
  byte unsigned tmp[$];

  always @(negedge clk) if (err_pulse === 1'b1) err_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold the byte until the decoder is ready; returns on the negedge after acceptance
  task automatic send_byte(input byte unsigned b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) begin
      checks++;
      failures++;
      $display("FAIL send_timeout observed=in_ready_low expected=accept_within_%0d", BOUND);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "byte never accepted");
    end
    @(negedge clk);
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) send_byte(stream[i]);
    in_valid = 1'b0;
  endtask

  task automatic build_frame();
    stream.delete();
    stream.push_back(ESC);
    stream.push_back(CSI_LBRACKET);
    stream.push_back(SEMI);
    stream.push_back(HOME_H);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) stream.push_back(cells[r * W + c] ? CELL_LIVE : CELL_DEAD);
      if (r < H - 1) begin
        stream.push_back(CR);
        stream.push_back(LF);
      end
    end
  endtask

  // Cells land in the buffer for every cell byte among the first n bytes of a frame
  task automatic model_apply(input int n);
    for (int p = 4; p < n; p++) begin
      int off, r, c;
      off = p - 4;
      r   = off / ROW_STRIDE;
      c   = off % ROW_STRIDE;
      if (c < W) exp_mem[r * W + c] = cells[r * W + c];
    end
  endtask

  task automatic randomize_cells();
    for (int i = 0; i < CELLS; i++) cells[i] = bit'($urandom_range(0, 1));
  endtask

  function automatic int popcount();
    int n;
    n = 0;
    for (int i = 0; i < CELLS; i++) n += int'(cells[i]);
    return n;
  endfunction

  task automatic readback_all(input string tag);
    int bad;
    bad = 0;
    for (int a = 0; a < CELLS; a++) begin
      rd_addr = 8'(a);
      @(negedge clk);
      check(tag, 32'(rd_data), 32'(exp_mem[a]));
    end
  endtask

  task automatic frame_done_checks();
    check("frame_valid_rise", 32'(frame_valid), 32'd1);
    check("in_ready_low_on_frame", 32'(in_ready), 32'd0);
    check("frame_live", 32'(frame_live), 32'(popcount()));
    check("frame_count", 32'(frame_count), 32'(exp_frames));
    repeat (2) @(negedge clk);
    check("err_count", 32'(err_count), 32'(exp_err));
    check("err_pulses_seen", 32'(err_seen), 32'(exp_pulses));
  endtask

  task automatic ack_frame();
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    check("ack_clears_valid", 32'(frame_valid), 32'd0);
    check("ack_raises_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int bp_bad;

    // Reset held with input activity
    rst_n = 1'b0;
    in_data = ESC;
    for (int i = 0; i < 6; i++) begin
      in_valid = ~in_valid;
      @(negedge clk);
    end
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    check("rst_frame_live", 32'(frame_live), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    check("release_in_ready_before_clk", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("release_in_ready_after_clk", 32'(in_ready), 32'd1);

    // Banner text then a glider frame
    stream.delete();
    for (int i = 0; i < 57; i++) stream.push_back(8'($urandom_range(32, 126)));
    send_range(0, 57);
    for (int i = 0; i < CELLS; i++) cells[i] = 1'b0;
    cells[1] = 1'b1; cells[18] = 1'b1; cells[32] = 1'b1; cells[33] = 1'b1; cells[34] = 1'b1;
    build_frame();
    check("frame_len", 32'(stream.size()), 32'(FRAME_BYTES));
    model_apply(FRAME_BYTES);
    exp_frames = 1;
    send_range(0, FRAME_BYTES);
    frame_done_checks();
    check("glider_live_5", 32'(frame_live), 32'd5);
    rd_addr = 8'd18;
    @(negedge clk);
    check("rd_18", 32'(rd_data), 32'd1);
    rd_addr = 8'd17;
    @(negedge clk);
    check("rd_17", 32'(rd_data), 32'd0);
    readback_all("glider_readback");

    // Backpressure: next frame waits while the frame is held
    rd_addr  = 8'd18;
    in_data  = ESC;
    in_valid = 1'b1;
    bp_bad   = 0;
    @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      if (in_ready !== 1'b0 || rd_data !== 1'b1 || frame_valid !== 1'b1) bp_bad++;
      @(negedge clk);
    end
    check("backpressure_stall_cycles", 32'(bp_bad), 32'd0);
    check("backpressure_count_held", 32'(frame_count), 32'd1);
    ack_frame();
    randomize_cells();
    build_frame();
    model_apply(FRAME_BYTES);
    exp_frames = 2;
    send_range(0, FRAME_BYTES);
    frame_done_checks();
    readback_all("frame2_readback");
    ack_frame();

    // Ack while idle must have no effect
    frame_ack = 1'b1;
    repeat (3) @(negedge clk);
    frame_ack = 1'b0;
    check("idle_ack_ignored", 32'(frame_valid), 32'd0);

    // Bad cell byte at row 3 column 5 aborts the frame
    randomize_cells();
    build_frame();
    while (stream.size() > 4 + 3 * ROW_STRIDE + 5) void'(stream.pop_back());
    stream.push_back(8'h58);
    model_apply(4 + 3 * ROW_STRIDE + 5);
    exp_err = 1;
    exp_pulses = 1;
    send_range(0, stream.size());
    repeat (3) @(negedge clk);
    check("abort_err_pulses", 32'(err_seen), 32'd1);
    check("abort_err_count", 32'(err_count), 32'd1);
    check("abort_no_frame", 32'(frame_valid), 32'd0);
    check("abort_frame_count", 32'(frame_count), 32'd2);
    readback_all("abort_partial_readback");
    randomize_cells();
    build_frame();
    model_apply(FRAME_BYTES);
    exp_frames = 3;
    send_range(0, FRAME_BYTES);
    frame_done_checks();
    readback_all("post_abort_readback");
    ack_frame();

    // ESC in the CR slot of row 0 resynchronises onto a new header
    randomize_cells();
    build_frame();
    tmp = stream;
    stream.delete();
    for (int i = 0; i < 4 + W; i++) stream.push_back(tmp[i]);
    stream.push_back(ESC);
    for (int i = 1; i < FRAME_BYTES; i++) stream.push_back(tmp[i]);
    model_apply(FRAME_BYTES);
    exp_err = 2;
    exp_pulses = 2;
    exp_frames = 4;
    send_range(0, stream.size());
    frame_done_checks();
    readback_all("resync_readback");
    ack_frame();

    // Asynchronous reset after 100 bytes of a frame
    randomize_cells();
    build_frame();
    model_apply(100);
    send_range(0, 100);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    check("midrst_frame_count", 32'(frame_count), 32'd0);
    check("midrst_err_count", 32'(err_count), 32'd0);
    check("midrst_frame_valid", 32'(frame_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_frame_live", 32'(frame_live), 32'd0);
    @(negedge clk);
    check("midrst_in_ready_after_clk", 32'(in_ready), 32'd1);
    exp_err = 0;
    randomize_cells();
    build_frame();
    model_apply(FRAME_BYTES);
    exp_frames = 1;
    send_range(0, FRAME_BYTES);
    frame_done_checks();
    readback_all("post_reset_readback");
    ack_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
